// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: shared FSM state type and default parameter values for freq_meter
package freq_meter_pkg;
  typedef enum logic {IDLE, GATE} state_t;
  localparam int GATE_CYCLES_DEF = 50000;
  localparam int CNT_W_DEF = 16;
  localparam int PER_W_DEF = 24;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus history flop producing a rising-edge pulse
module sync_edge_det
  import freq_meter_pkg::*;
(
  input  logic clk_in,
  input  logic rst_n,
  input  logic sig_in,
  output logic edge_pulse
);
  logic s1_q, s1_d, s2_q, s2_d, hist_q, hist_d;
  // shift the raw input through the synchronizer and history stage
  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    hist_d = s2_q;
  end
  // synchronizer and history registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      hist_q <= hist_d;
    end
  end
  assign edge_pulse = s2_q & ~hist_q;
endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated edge counter with optional period measurement (FREQ_METER_PERIOD_EN)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int PER_W = PER_W_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             overflow
`ifdef FREQ_METER_PERIOD_EN
  ,
  output logic [PER_W-1:0] period,
  output logic             period_valid
`endif
);
  localparam int TW = $clog2(GATE_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_MAX = '1;
  state_t state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nx, freq_count_q, freq_count_d;
  logic flag_q, flag_d, flag_nx, overflow_q, overflow_d, freq_valid_q, freq_valid_d;
  logic edge_p, sat;
  sync_edge_det u_sync (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .sig_in(sig_in),
    .edge_pulse(edge_p)
  );
  // gate FSM: count edges over the window, publish at its last cycle and restart
  always_comb begin
    sat = edge_p && (cnt_q == C_MAX);
    cnt_nx = (edge_p && !sat) ? cnt_q + 1'b1 : cnt_q;
    flag_nx = flag_q | sat;
    state_d = state_q;
    timer_d = '0;
    cnt_d = '0;
    flag_d = 1'b0;
    freq_count_d = freq_count_q;
    overflow_d = overflow_q;
    freq_valid_d = 1'b0;
    if (state_q == IDLE) begin
      state_d = enable ? GATE : IDLE;
    end else if (!enable) begin
      state_d = IDLE;
    end else if (timer_q == T_LAST) begin
      freq_count_d = cnt_nx;
      overflow_d = flag_nx;
      freq_valid_d = 1'b1;
    end else begin
      timer_d = timer_q + 1'b1;
      cnt_d = cnt_nx;
      flag_d = flag_nx;
    end
  end
  // gate FSM and result registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q <= '0;
      flag_q <= 1'b0;
      freq_count_q <= '0;
      overflow_q <= 1'b0;
      freq_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q <= cnt_d;
      flag_q <= flag_d;
      freq_count_q <= freq_count_d;
      overflow_q <= overflow_d;
      freq_valid_q <= freq_valid_d;
    end
  end
  assign freq_count = freq_count_q;
  assign freq_valid = freq_valid_q;
  assign overflow = overflow_q;
`ifdef FREQ_METER_PERIOD_EN
  localparam logic [PER_W-1:0] P_MAX = '1;
  logic [PER_W-1:0] per_q, per_d, per_inc, period_q, period_d;
  logic first_q, first_d, period_valid_q, period_valid_d;
  // period counter: the first edge only arms, later edges publish counter+1
  always_comb begin
    per_inc = (per_q == P_MAX) ? per_q : per_q + 1'b1;
    per_d = per_inc;
    first_d = first_q;
    period_d = period_q;
    period_valid_d = 1'b0;
    if (!enable) begin
      per_d = '0;
      first_d = 1'b0;
    end else if (edge_p) begin
      per_d = '0;
      first_d = 1'b1;
      period_valid_d = first_q;
      period_d = first_q ? per_inc : period_q;
    end
  end
  // period registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      per_q <= '0;
      first_q <= 1'b0;
      period_q <= '0;
      period_valid_q <= 1'b0;
    end else begin
      per_q <= per_d;
      first_q <= first_d;
      period_q <= period_d;
      period_valid_q <= period_valid_d;
    end
  end
  assign period = period_q;
  assign period_valid = period_valid_q;
`endif
endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: scoreboard-driven checks of gating, saturation, abort, reset and period
module tb_freq_meter;
  logic clk_in = 1'b0, rst_n = 1'b0, en_a = 1'b0, en_b = 1'b0, gen = 1'b0, sig_man = 1'b0;
  logic sig_in;
  logic [15:0] fc_a;
  logic [3:0] fc_b;
  logic fv_a, ov_a, fv_b, ov_b;
  int cyc = 0, sig_per = 0, ph = 0, n_chk = 0, n_fail = 0;
  typedef struct {int cnt; bit ovf; int tol;} exp_t;
  exp_t q[$];
  int pq[$];
`ifdef FREQ_METER_PERIOD_EN
  logic [23:0] per_a, per_b;
  logic pv_a, pv_b;
`endif
  freq_meter #(.GATE_CYCLES(100), .CNT_W(16), .PER_W(24)) dut_a (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(en_a),
    .freq_count(fc_a), .freq_valid(fv_a), .overflow(ov_a)
`ifdef FREQ_METER_PERIOD_EN
    , .period(per_a), .period_valid(pv_a)
`endif
  );
  freq_meter #(.GATE_CYCLES(100), .CNT_W(4), .PER_W(24)) dut_b (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in), .enable(en_b),
    .freq_count(fc_b), .freq_valid(fv_b), .overflow(ov_b)
`ifdef FREQ_METER_PERIOD_EN
    , .period(per_b), .period_valid(pv_b)
`endif
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc++;
  assign sig_in = (sig_per != 0) ? gen : sig_man;
  initial forever begin
    @(posedge clk_in);
    #1;
    if (sig_per != 0) begin
      ph = (ph + 1 >= sig_per) ? 0 : ph + 1;
      gen = (ph < sig_per / 2);
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic wait_valid(input bit sel, input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_in);
      if ((sel ? fv_b : fv_a) === 1'b1) begin
        t = cyc;
        break;
      end
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    tick(3);
    n_chk++;
    if ({fc_a, fv_a, ov_a} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_a got fc=%0d fv=%b ov=%b want 0", fc_a, fv_a, ov_a);
    end
    n_chk++;
    if ({fc_b, fv_b, ov_b} !== 6'd0) begin
      n_fail++;
      $display("FAIL reset_b got fc=%0d fv=%b ov=%b want 0", fc_b, fv_b, ov_b);
    end
`ifdef FREQ_METER_PERIOD_EN
    n_chk++;
    if ({per_a, pv_a} !== 25'd0) begin
      n_fail++;
      $display("FAIL reset_period got per=%0d pv=%b want 0", per_a, pv_a);
    end
`endif
    rst_n = 1'b1;
    tick(2);
  endtask
  task automatic test_freq;
    int t, t0, d;
    exp_t e;
    sig_per = 10;
    tick(20);
    en_a = 1'b1;
    t0 = cyc;
    for (int w = 0; w < 3; w++) begin
      q.push_back('{10, 1'b0, 1});
      wait_valid(1'b0, 250, t);
      e = q.pop_front();
      d = int'(fc_a) - e.cnt;
      n_chk++;
      if (t != t0 + 101 + 100 * w) begin
        n_fail++;
        $display("FAIL freq_time w%0d got %0d want %0d", w, t, t0 + 101 + 100 * w);
      end
      n_chk++;
      if (d > e.tol || d < -e.tol || ov_a !== e.ovf) begin
        n_fail++;
        $display("FAIL freq_count w%0d got %0d/%b want %0d+-%0d/%b", w, fc_a, ov_a, e.cnt, e.tol, e.ovf);
      end
      @(negedge clk_in);
      n_chk++;
      if (fv_a !== 1'b0) begin
        n_fail++;
        $display("FAIL freq_pulse w%0d got %b want 0", w, fv_a);
      end
    end
    en_a = 1'b0;
    tick(3);
  endtask
  task automatic test_overflow;
    int t, t0;
    exp_t e;
    sig_per = 4;
    tick(8);
    en_b = 1'b1;
    t0 = cyc;
    q.push_back('{15, 1'b1, 0});
    wait_valid(1'b1, 250, t);
    e = q.pop_front();
    n_chk++;
    if (t != t0 + 101 || int'(fc_b) != e.cnt || ov_b !== e.ovf) begin
      n_fail++;
      $display("FAIL sat_window got t=%0d fc=%0d ov=%b want t=%0d fc=%0d ov=%b", t, fc_b, ov_b, t0 + 101, e.cnt, e.ovf);
    end
    sig_per = 20;
    wait_valid(1'b1, 250, t);
    n_chk++;
    if (t != t0 + 201) begin
      n_fail++;
      $display("FAIL sat_transition_time got %0d want %0d", t, t0 + 201);
    end
    q.push_back('{5, 1'b0, 0});
    wait_valid(1'b1, 250, t);
    e = q.pop_front();
    n_chk++;
    if (t != t0 + 301 || int'(fc_b) != e.cnt || ov_b !== e.ovf) begin
      n_fail++;
      $display("FAIL sat_recover got t=%0d fc=%0d ov=%b want t=%0d fc=%0d ov=%b", t, fc_b, ov_b, t0 + 301, e.cnt, e.ovf);
    end
    en_b = 1'b0;
    tick(3);
  endtask
  task automatic test_abort;
    int t, t0, nv, d;
    exp_t e;
    sig_per = 10;
    en_a = 1'b1;
    q.push_back('{10, 1'b0, 1});
    wait_valid(1'b0, 250, t);
    e = q.pop_front();
    d = int'(fc_a) - e.cnt;
    n_chk++;
    if (t < 0 || d > e.tol || d < -e.tol) begin
      n_fail++;
      $display("FAIL abort_pre got t=%0d fc=%0d want %0d+-%0d", t, fc_a, e.cnt, e.tol);
    end
    tick(50);
    en_a = 1'b0;
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (fv_a === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 0) begin
      n_fail++;
      $display("FAIL abort_no_valid got %0d pulses want 0", nv);
    end
    d = int'(fc_a) - e.cnt;
    n_chk++;
    if (d > e.tol || d < -e.tol || ov_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_hold got fc=%0d ov=%b want %0d+-%0d ov=0", fc_a, ov_a, e.cnt, e.tol);
    end
    tick(1);
    en_a = 1'b1;
    t0 = cyc;
    q.push_back('{10, 1'b0, 1});
    wait_valid(1'b0, 250, t);
    e = q.pop_front();
    d = int'(fc_a) - e.cnt;
    n_chk++;
    if (t != t0 + 101 || d > e.tol || d < -e.tol) begin
      n_fail++;
      $display("FAIL abort_reenable got t=%0d fc=%0d want t=%0d fc=%0d+-%0d", t, fc_a, t0 + 101, e.cnt, e.tol);
    end
    en_a = 1'b0;
    tick(3);
  endtask
  task automatic test_rst_mid;
    int t, t0, d;
    exp_t e;
    sig_per = 10;
    en_a = 1'b1;
    en_b = 1'b1;
    tick(50);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({fc_a, fv_a, ov_a} !== 18'd0 || {fc_b, fv_b, ov_b} !== 6'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs got fc_a=%0d fc_b=%0d ov_b=%b want 0", fc_a, fc_b, ov_b);
    end
    en_b = 1'b0;
    tick(5);
    rst_n = 1'b1;
    t0 = cyc;
    q.push_back('{10, 1'b0, 1});
    wait_valid(1'b0, 250, t);
    e = q.pop_front();
    d = int'(fc_a) - e.cnt;
    n_chk++;
    if (t != t0 + 101) begin
      n_fail++;
      $display("FAIL rst_mid_time got %0d want %0d", t, t0 + 101);
    end
    n_chk++;
    if (d > e.tol || d < -e.tol || ov_a !== e.ovf) begin
      n_fail++;
      $display("FAIL rst_mid_count got %0d/%b want %0d+-%0d/%b", fc_a, ov_a, e.cnt, e.tol, e.ovf);
    end
    en_a = 1'b0;
    tick(3);
  endtask
  task automatic test_edge_at_end;
    int t, t0;
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      sig_man = 1'b0;
      sig_per = 0;
      tick(6);
      en_a = 1'b1;
      t0 = cyc;
      q.push_back('{(k == 0) ? 1 : 0, 1'b0, 0});
      q.push_back('{(k == 0) ? 0 : 1, 1'b0, 0});
      while (cyc < t0 + 98 + k) tick(1);
      sig_man = 1'b1;
      for (int w = 0; w < 2; w++) begin
        wait_valid(1'b0, 250, t);
        e = q.pop_front();
        n_chk++;
        if (t != t0 + 101 + 100 * w || int'(fc_a) != e.cnt || ov_a !== e.ovf) begin
          n_fail++;
          $display("FAIL edge_at_end k%0d w%0d got t=%0d fc=%0d want t=%0d fc=%0d", k, w, t, fc_a, t0 + 101 + 100 * w, e.cnt);
        end
      end
      en_a = 1'b0;
      tick(3);
    end
  endtask
`ifdef FREQ_METER_PERIOD_EN
  task automatic test_period;
    int t, tp, nv, want;
    bit got;
    sig_man = 1'b0;
    sig_per = 0;
    tick(4);
    en_a = 1'b1;
    tick(50);
    sig_per = 37;
    tp = -1;
    for (int i = 0; i < 4; i++) begin
      pq.push_back(37);
      got = 1'b0;
      t = -1;
      for (int j = 0; j < 200 && !got; j++) begin
        @(negedge clk_in);
        if (pv_a === 1'b1) begin
          got = 1'b1;
          t = cyc;
        end
      end
      want = pq.pop_front();
      n_chk++;
      if (!got || int'(per_a) != want) begin
        n_fail++;
        $display("FAIL period_value p%0d got %0d (seen=%b) want %0d", i, per_a, got, want);
      end
      if (i > 0) begin
        n_chk++;
        if (t - tp != 37) begin
          n_fail++;
          $display("FAIL period_spacing p%0d got %0d want 37", i, t - tp);
        end
      end
      tp = t;
    end
    sig_per = 0;
    nv = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (pv_a === 1'b1) nv++;
    end
    n_chk++;
    if (nv != 0 || per_a !== 24'd37) begin
      n_fail++;
      $display("FAIL period_hold got pulses=%0d per=%0d want 0 and 37", nv, per_a);
    end
    en_a = 1'b0;
    tick(3);
  endtask
`endif
  initial begin
    test_reset();
    test_freq();
    test_overflow();
    test_abort();
    test_rst_mid();
    test_edge_at_end();
`ifdef FREQ_METER_PERIOD_EN
    test_period();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/freq_meter.md
FREQ_METER -- requirements
Module: freq_meter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 50000, meaning gate window length in clk_in cycles (1 ms at 50 MHz); legal range 2..2^24-1.
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of the edge counter and of freq_count.
REQ-003 SHALL have parameter PER_W, default 24, meaning width of the period counter and of period.
REQ-004 clk_in  input  1  sole clock; all logic on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sig_in  input  1  asynchronous square wave to measure (sensor or divided clock).
REQ-007 enable  input  1  level; 1 runs back-to-back gate windows.
REQ-008 freq_count  output  CNT_W  rising edges counted in the last completed window.
REQ-009 freq_valid  output  1  one-cycle pulse when freq_count updates.
REQ-010 overflow  output  1  edge counter saturated in the last completed window; updates with freq_valid.
REQ-011 period  output  PER_W  clk_in cycles between the last two detected edges (FREQ_METER_PERIOD_EN only).
REQ-012 period_valid  output  1  one-cycle pulse when period updates (FREQ_METER_PERIOD_EN only).

Function
REQ-013 sig_in SHALL pass a 2-flop synchronizer plus a history flop; a rising edge is detected when sync2=1 and hist=0; detection occurs 3 clk_in cycles after the sig_in transition.
REQ-014 The FSM SHALL have states IDLE and GATE.
REQ-015 In IDLE: gate timer and edge counter held at 0. enable=1 sampled -> GATE next cycle with timer=0.
REQ-016 In GATE: the timer increments each cycle; each detected edge increments the edge counter.
REQ-017 The edge counter SHALL saturate at 2^CNT_W-1 and set an internal sticky window-overflow flag.
REQ-018 When timer==GATE_CYCLES-1, in the same cycle:
- freq_count <= edge count, including any edge detected in that cycle;
- overflow <= window flag;
- freq_valid=1 for exactly one cycle;
- timer, counter and flag restart at 0 with no dead cycle.
REQ-019 enable=0 in GATE SHALL abort the window: return to IDLE next cycle, no freq_valid, freq_count and overflow keep prior values.
REQ-020 Edge and window end coinciding: the edge counts in the ending window, not the next.
REQ-021 freq_count SHALL equal round(f_sig * GATE_CYCLES / f_clk) within ±1.

Reset
REQ-022 rst_n=0 SHALL immediately force:
- state IDLE;
- freq_count=0, freq_valid=0, overflow=0, period=0, period_valid=0;
- synchronizer, history flop, timer, counters and first-edge flag to 0.
REQ-023 Reset mid-window SHALL discard that window; after release, no freq_valid until a full GATE_CYCLES window completes with enable=1.

Configuration
REQ-024 With FREQ_METER_PERIOD_EN defined:
- a PER_W counter increments every cycle while enable=1, saturating at 2^PER_W-1;
- on each detected edge after the first since enable rose: period <= counter+1, period_valid pulses, counter restarts;
- the first edge only restarts the counter and arms the first-edge flag;
- enable=0 clears counter and flag.
REQ-025 Without FREQ_METER_PERIOD_EN, ports period and period_valid and all period logic SHALL be absent.

Structure
REQ-026 Package freq_meter_pkg SHALL hold the FSM state typedef (IDLE, GATE) and the default constants GATE_CYCLES_DEF=50000, CNT_W_DEF=16, PER_W_DEF=24.
REQ-027 Sub-module sync_edge_det SHALL implement the synchronizer, history flop and rising-edge pulse; freq_meter instantiates it once.

Verification
REQ-028 GATE_CYCLES=100, sig_in period 10 cycles, enable=1 -> freq_valid every 100 cycles, freq_count=10 (±1), overflow=0.
REQ-029 CNT_W=4, GATE_CYCLES=100, sig_in period 4 -> freq_count=15, overflow=1; then slow sig_in to period 20 -> next window freq_count=5, overflow=0.
REQ-030 enable dropped at cycle 50 of a 100-cycle window -> no freq_valid, freq_count keeps prior value; re-enable -> first freq_valid 100 cycles later.
REQ-031 rst_n pulsed low mid-window -> all outputs 0 immediately; first freq_valid exactly GATE_CYCLES cycles after enable is seen in IDLE.
REQ-032 Edge detected exactly at timer==GATE_CYCLES-1 -> counted in the ending window; next window starts at 0.
REQ-033 FREQ_METER_PERIOD_EN, sig_in period 37 cycles -> first edge gives no pulse; every later edge gives period=37 with period_valid; sig_in held low -> period holds, no pulses.
